// File: rtl/data_loader_sync.sv
// data_loader_sync
//   Single-clock bridge-write loader. Each accepted 32-bit bridge write is
//   queued in a small FIFO, then a drain FSM splits it into 4 bytes or
//   2 half-words and emits them to a memory, one write_en pulse every
//   WRITE_MEM_CLOCK_DELAY clocks, at ascending byte addresses.
//
// Ports
//   clk_74a              in   sole clock
//   reset                in   asynchronous, active-high
//   bridge_wr            in   write strobe (rising edge = one write)
//   bridge_endian_little in   1 = little-endian word, 0 = big-endian
//   bridge_addr          in   [31:0] byte address of the bridge word
//   bridge_wr_data       in   [31:0] bridge write data
//   write_en             out  one-cycle memory write strobe
//   write_addr           out  [ADDRESS_SIZE-1:0] memory byte address
//   write_data           out  [8*OUTPUT_WORD_SIZE-1:0] memory write data
//   busy                 out  FIFO non-empty or drain FSM active
//   overflow             out  sticky, set when a bridge write is dropped
module data_loader_sync #(
    parameter logic [3:0] ADDRESS_MASK_UPPER_4  = 4'h0,
    parameter int         ADDRESS_SIZE          = 28,
    parameter int         WRITE_MEM_CLOCK_DELAY = 1,
    parameter int         OUTPUT_WORD_SIZE      = 1,
    parameter int         FIFO_DEPTH            = 4
) (
    input  logic                          clk_74a,
    input  logic                          reset,
    input  logic                          bridge_wr,
    input  logic                          bridge_endian_little,
    input  logic [31:0]                   bridge_addr,
    input  logic [31:0]                   bridge_wr_data,
    output logic                          write_en,
    output logic [ADDRESS_SIZE-1:0]       write_addr,
    output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
    output logic                          busy,
    output logic                          overflow
);
    localparam int W  = 8 * OUTPUT_WORD_SIZE;
    localparam int N  = 4 / OUTPUT_WORD_SIZE;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]             FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [1:0]              LAST_K   = 2'(N - 1);
    localparam logic [ADDRESS_SIZE-1:0] STRIDE   = ADDRESS_SIZE'(OUTPUT_WORD_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, WAIT} state_t;

    function automatic logic [31:0] normalise(input logic [31:0] d, input logic le);
        return le ? d : {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // FIFO storage (contents need no reset; pointers and count do)
    logic [ADDRESS_SIZE-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0]             fifo_data_q [FIFO_DEPTH];
    logic                    fifo_le_q   [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [PW:0]             count_q, count_d;

    state_t                  state_q, state_d;
    logic                    prev_wr_q;
    logic                    overflow_q;
    logic [1:0]              k_q, k_d;
    logic [3:0]              wait_q, wait_d;
    logic [ADDRESS_SIZE-1:0] base_q, base_d;
    logic [31:0]             norm_q, norm_d;
    logic                    we_q, we_d;
    logic [ADDRESS_SIZE-1:0] waddr_q, waddr_d;
    logic [W-1:0]            wdata_q, wdata_d;

    logic                    accept, push, pop, step, emit;
    logic [1:0]              sel_k;
    logic [ADDRESS_SIZE-1:0] sel_base;
    logic [31:0]             sel_norm;

    assign accept = bridge_wr & ~prev_wr_q & (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
    assign push   = accept & ((count_q != FULL_CNT) | pop);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wait_d   = wait_q;
        base_d   = base_q;
        norm_d   = norm_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        pop      = 1'b0;
        step     = 1'b0;
        emit     = 1'b0;
        sel_k    = k_q;
        sel_base = base_q;
        sel_norm = norm_q;
        case (state_q)
            IDLE: if (count_q != '0) state_d = LOAD;
            LOAD: begin
                pop      = 1'b1;
                base_d   = fifo_addr_q[rd_ptr_q];
                norm_d   = normalise(fifo_data_q[rd_ptr_q], fifo_le_q[rd_ptr_q]);
                k_d      = 2'd0;
                sel_k    = 2'd0;
                sel_base = base_d;
                sel_norm = norm_d;
                emit     = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                if (WRITE_MEM_CLOCK_DELAY == 1) begin
                    step = 1'b1;
                end else begin
                    wait_d  = 4'(WRITE_MEM_CLOCK_DELAY - 2);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) step = 1'b1;
                else                wait_d = wait_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (step) begin
            if (k_q == LAST_K) begin
                state_d = IDLE;
            end else begin
                k_d     = k_q + 2'd1;
                sel_k   = k_d;
                emit    = 1'b1;
                state_d = WRITE;
            end
        end

        // Outputs are registered on entry to WRITE, so they hold while write_en is low.
        if (emit) begin
            we_d    = 1'b1;
            waddr_d = sel_base + ADDRESS_SIZE'(sel_k) * STRIDE;
            wdata_d = W'(sel_norm >> (int'(sel_k) * W));
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_wr_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            k_q        <= 2'd0;
            wait_q     <= 4'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q   <= state_d;
            prev_wr_q <= bridge_wr;
            if (accept && !push) overflow_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            k_q       <= k_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bridge_addr[ADDRESS_SIZE-1:0];
            fifo_data_q[wr_ptr_q] <= bridge_wr_data;
            fifo_le_q[wr_ptr_q]   <= bridge_endian_little;
        end
        base_q <= base_d;
        norm_q <= norm_d;
    end

    assign write_en   = we_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;
    assign busy       = (count_q != '0) || (state_q != IDLE);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_data_loader_sync.sv
module tb_data_loader_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        endian = 1'b1;
    logic [31:0] addr = '0, data = '0;
    logic        wr_a = 1'b0, wr_b = 1'b0, wr_c = 1'b0;

    logic        we_a, we_b, we_c;
    logic [27:0] wa_a, wa_b, wa_c;
    logic [7:0]  wd_a, wd_c;
    logic [15:0] wd_b;
    logic        busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [27:0] a;
        logic [15:0] d;
        int          c;
    } ev_t;
    ev_t qa[$], qb[$], qc[$];

    // A: bytes, delay 1
    data_loader_sync #(.ADDRESS_MASK_UPPER_4(4'h0), .ADDRESS_SIZE(28), .WRITE_MEM_CLOCK_DELAY(1),
                       .OUTPUT_WORD_SIZE(1), .FIFO_DEPTH(4)) dut_a (
        .clk_74a(clk), .reset(rst), .bridge_wr(wr_a), .bridge_endian_little(endian),
        .bridge_addr(addr), .bridge_wr_data(data), .write_en(we_a), .write_addr(wa_a),
        .write_data(wd_a), .busy(busy_a), .overflow(ovf_a));

    // B: half-words, delay 3
    data_loader_sync #(.ADDRESS_MASK_UPPER_4(4'h0), .ADDRESS_SIZE(28), .WRITE_MEM_CLOCK_DELAY(3),
                       .OUTPUT_WORD_SIZE(2), .FIFO_DEPTH(4)) dut_b (
        .clk_74a(clk), .reset(rst), .bridge_wr(wr_b), .bridge_endian_little(endian),
        .bridge_addr(addr), .bridge_wr_data(data), .write_en(we_b), .write_addr(wa_b),
        .write_data(wd_b), .busy(busy_b), .overflow(ovf_b));

    // C: bytes, delay 4, depth 4
    data_loader_sync #(.ADDRESS_MASK_UPPER_4(4'h0), .ADDRESS_SIZE(28), .WRITE_MEM_CLOCK_DELAY(4),
                       .OUTPUT_WORD_SIZE(1), .FIFO_DEPTH(4)) dut_c (
        .clk_74a(clk), .reset(rst), .bridge_wr(wr_c), .bridge_endian_little(endian),
        .bridge_addr(addr), .bridge_wr_data(data), .write_en(we_c), .write_addr(wa_c),
        .write_data(wd_c), .busy(busy_c), .overflow(ovf_c));

    always @(negedge clk) begin
        if (we_a === 1'b1) qa.push_back('{a: wa_a, d: {8'h00, wd_a}, c: cyc});
        if (we_b === 1'b1) qb.push_back('{a: wa_b, d: wd_b, c: cyc});
        if (we_c === 1'b1) qc.push_back('{a: wa_c, d: {8'h00, wd_c}, c: cyc});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_wr(input int which, input logic v);
        case (which)
            0: wr_a = v;
            1: wr_b = v;
            default: wr_c = v;
        endcase
    endtask

    // Rising edge of bridge_wr at a negedge; e = cycle number just after the accepting edge.
    task automatic bridge_write(input int which, input logic [31:0] a, input logic [31:0] d,
                                input logic le, input int hold, output int e);
        @(negedge clk);
        addr = a; data = d; endian = le;
        set_wr(which, 1'b1);
        @(posedge clk);
        #1 e = cyc;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        set_wr(which, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Four byte writes from dut_a: address a0+k, byte k of exp, cycle e+2+k.
    task automatic expect_a(input string tag, input logic [27:0] a0, input logic [31:0] exp, input int e);
        logic [27:0] ea;
        check({tag, "_count"}, qa.size(), 4);
        for (int k = 0; k < 4 && k < qa.size(); k++) begin
            ea = a0 + 28'(k);
            check($sformatf("%s_addr%0d", tag, k), qa[k].a, ea);
            check($sformatf("%s_data%0d", tag, k), qa[k].d, {8'h00, exp[k*8 +: 8]});
            check($sformatf("%s_cyc%0d", tag, k), qa[k].c, e + 2 + k);
        end
    endtask

    initial begin
        int e;
        int n;
        logic [27:0] ea;

        // Reset state
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_we", we_a, 0);
        check("rst_addr", wa_a, 0);
        check("rst_data", wd_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ovf", ovf_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Byte mode, little-endian
        qa.delete();
        bridge_write(0, 32'h0000_0100, 32'hDDCC_BBAA, 1'b1, 1, e);
        repeat (20) @(negedge clk);
        expect_a("le", 28'h100, 32'hDDCC_BBAA, e);
        check("le_busy", busy_a, 0);

        // Byte mode, big-endian
        qa.delete();
        bridge_write(0, 32'h0000_0100, 32'hDDCC_BBAA, 1'b0, 1, e);
        repeat (20) @(negedge clk);
        expect_a("be", 28'h100, 32'hAABB_CCDD, e);

        // Half-word mode, delay 3
        qb.delete();
        bridge_write(1, 32'h0000_0020, 32'h4433_2211, 1'b1, 1, e);
        repeat (20) @(negedge clk);
        check("hw_count", qb.size(), 2);
        if (qb.size() >= 2) begin
            check("hw_addr0", qb[0].a, 28'h20);
            check("hw_data0", qb[0].d, 16'h2211);
            check("hw_cyc0", qb[0].c, e + 2);
            check("hw_addr1", qb[1].a, 28'h22);
            check("hw_data1", qb[1].d, 16'h4433);
            check("hw_cyc1", qb[1].c, e + 5);
        end

        // Non-matching upper address nibble
        qa.delete();
        bridge_write(0, 32'h1000_0100, 32'h1234_5678, 1'b1, 1, e);
        check("nm_busy_now", busy_a, 0);
        repeat (20) @(negedge clk);
        check("nm_count", qa.size(), 0);
        check("nm_ovf", ovf_a, 0);
        check("nm_busy", busy_a, 0);

        // Held-high strobe counts once
        qa.delete();
        bridge_write(0, 32'h0000_0300, 32'h0403_0201, 1'b1, 10, e);
        repeat (30) @(negedge clk);
        expect_a("hold", 28'h300, 32'h0403_0201, e);

        // Address wrap
        qa.delete();
        bridge_write(0, 32'h0FFF_FFFE, 32'hDDCC_BBAA, 1'b1, 1, e);
        repeat (20) @(negedge clk);
        expect_a("wrap", 28'hFFF_FFFE, 32'hDDCC_BBAA, e);

        // Overflow: six writes two cycles apart into depth-4 FIFO, delay 4
        qc.delete();
        for (int j = 0; j < 6; j++)
            bridge_write(2, 32'h0000_1000 + 32'(j) * 32'h10,
                         {8'(8'h30 + j), 8'(8'h20 + j), 8'(8'h10 + j), 8'(j)}, 1'b1, 1, e);
        check("ovf_set", ovf_c, 1);
        n = 0;
        while (busy_c === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ovf_busy_timeout", n < 400, 1);
        check("ovf_count", qc.size(), 20);
        for (int i = 0; i < 20 && i < qc.size(); i++) begin
            ea = 28'h1000 + 28'(i / 4) * 28'h10 + 28'(i % 4);
            check($sformatf("ovf_addr%0d", i), qc[i].a, ea);
            check($sformatf("ovf_data%0d", i), qc[i].d, {8'h00, 8'(16 * (i % 4) + i / 4)});
        end
        if (qc.size() >= 2) check("ovf_spacing", qc[1].c - qc[0].c, 4);
        repeat (5) @(negedge clk);
        check("ovf_sticky", ovf_c, 1);
        check("ovf_busy_end", busy_c, 0);

        // Reset mid-entry after second byte (also clears the sticky overflow on C)
        qa.delete();
        bridge_write(0, 32'h0000_0200, 32'h0403_0201, 1'b1, 1, e);
        n = 0;
        while (cyc < e + 3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check("mid_we", we_a, 0);
        check("mid_busy", busy_a, 0);
        check("mid_ovf_a", ovf_a, 0);
        check("mid_ovf_c", ovf_c, 0);
        check("mid_count_at_rst", qa.size(), 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_count_after", qa.size(), 2);
        check("mid_busy_after", busy_a, 0);
        if (qa.size() >= 2) begin
            check("mid_addr1", qa[1].a, 28'h201);
            check("mid_data1", qa[1].d, 16'h0002);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_loader_sync.md
Name: data_loader_sync

Overview:
- Consumes APF bridge writes (32-bit words) and splits each into 4 bytes or 2 16-bit words.
- Writes them sequentially to an underlying memory at a configurable write cadence.
- Single-clock counterpart of the bridge read-side unloader. Used where the memory runs on the bridge clock (e.g. BRAM-backed save RAM) and no CDC FIFO is needed.
- Buffers up to FIFO_DEPTH pending bridge writes so back-to-back bridge bursts are not lost.

Parameters:
- ADDRESS_MASK_UPPER_4, 0: bridge_addr[31:28] value this block responds to.
- ADDRESS_SIZE, 28: width of write_addr; memory address = bridge_addr[ADDRESS_SIZE-1:0].
- WRITE_MEM_CLOCK_DELAY, 1: clocks between successive write_en pulses, 1..15.
- OUTPUT_WORD_SIZE, 1: bytes per memory word, 1 (8-bit) or 2 (16-bit).
- FIFO_DEPTH, 4: number of buffered {addr, data, endian} entries, power of 2, 2..16.

Ports:
- clk_74a, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high.
- bridge_wr, in, 1: APF write strobe (level; rising edge = one write).
- bridge_endian_little, in, 1: 1 = little-endian word, 0 = big-endian.
- bridge_addr, in, 32: byte address of the bridge word.
- bridge_wr_data, in, 32: bridge write data.
- write_en, out, 1: one-cycle memory write strobe.
- write_addr, out, ADDRESS_SIZE: memory byte address.
- write_data, out, 8*OUTPUT_WORD_SIZE: memory write data.
- busy, out, 1: FIFO non-empty or drain FSM not IDLE.
- overflow, out, 1: sticky; set when a bridge write is dropped.

Behaviour:
- Reset (async, any time, including mid-burst): write_en=0, write_addr=0, write_data=0, busy=0, overflow=0, prev_wr=0, FIFO emptied, FSM=IDLE. Pending entries are discarded.
- Edge detect: prev_wr <= bridge_wr each clock. Accept when bridge_wr & ~prev_wr & bridge_addr[31:28]==ADDRESS_MASK_UPPER_4. A held-high bridge_wr counts once. Non-matching addresses are ignored, with no overflow.
- Push: on accept, write {bridge_addr[ADDRESS_SIZE-1:0], bridge_wr_data, bridge_endian_little} into the FIFO at that edge. Endianness is captured per entry.
- Full case: the push is accepted if count<FIFO_DEPTH or a pop occurs the same cycle. Otherwise the write is dropped and overflow<=1.
- Normalisation: norm = endian_little ? data : {data[7:0],data[15:8],data[23:16],data[31:24]}.
- Sub-word k (k=0..N-1, N=4/OUTPUT_WORD_SIZE) = norm[k*W +: W], W=8*OUTPUT_WORD_SIZE.
- Sub-word address = base + k*OUTPUT_WORD_SIZE, computed in ADDRESS_SIZE bits; wraps mod 2^ADDRESS_SIZE.
- Drain FSM:
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD: pop head into working registers; k=0 -> WRITE.
  - WRITE: write_en=1 for exactly this cycle, with write_addr/write_data for sub-word k. If WRITE_MEM_CLOCK_DELAY==1 go straight to the next step; else -> WAIT.
  - WAIT: hold write_en=0 for WRITE_MEM_CLOCK_DELAY-1 cycles, then next step.
  - Next step: k<N-1 -> k+1, WRITE. Else -> IDLE.
- write_addr and write_data hold their last values while write_en=0.
- Latency: accept sampled at edge E -> LOAD after E+1 -> first write_en high after E+2. Subsequent write_en pulses are every WRITE_MEM_CLOCK_DELAY cycles.
- One entry occupies 1 + N*WRITE_MEM_CLOCK_DELAY cycles, plus 1 IDLE cycle before the next LOAD.
- A simultaneous push and pop at a full FIFO leaves count unchanged and drops nothing.
- busy is registered/combinational from state; it deasserts the cycle after the final WRITE/WAIT returns to IDLE with an empty FIFO.

Test Plan:
- Byte mode, delay 1, little, addr 0x0000_0100, data 0xDDCCBBAA -> four write_en pulses on consecutive cycles starting E+2: (0x100,AA),(0x101,BB),(0x102,CC),(0x103,DD).
- Byte mode, big-endian, same data -> (0x100,DD),(0x101,CC),(0x102,BB),(0x103,AA).
- OUTPUT_WORD_SIZE=2, delay 3, little, addr 0x20, data 0x44332211 -> (0x20,0x2211) at E+2, (0x22,0x4433) at E+5. write_en low between pulses.
- Depth 4, delay 4: 6 bridge writes 2 cycles apart -> first 5 written in order (one popped early frees a slot), 6th dropped, overflow=1 and stays 1; busy falls after last write.
- bridge_addr[31:28]=0x1 with mask 0 -> no write_en, no FIFO activity, overflow=0. Also: bridge_wr held high 10 cycles -> exactly one entry.
- Reset asserted mid-entry after 2nd byte -> write_en drops immediately; no further writes after release; busy=0, overflow=0. Also: addr 0xFFFFFFE with ADDRESS_SIZE=28 -> byte addresses wrap to 0x0000000, 0x0000001.
